// File: rtl/embedding_stream_lookup.sv
// rtl/embedding_stream_lookup.sv - embedding table lookup streaming one vector per index in LANES-wide beats
// Each beat takes FETCH (read issue), LOAD (capture into the output register) and SEND (handshake).
module embedding_stream_lookup #(
    parameter int    DATA_WIDTH  = 8,
    parameter int    EMB_DIM     = 8,
    parameter int    LANES       = 4,
    parameter int    NUM_ENTRIES = 1024,
    parameter int    IDX_WIDTH   = 10,
    parameter string INIT_FILE   = ""
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IDX_WIDTH-1:0]        in_index,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic                        out_last,
    output logic                        out_err,
    output logic [IDX_WIDTH-1:0]        out_index
);

    localparam int BEATS  = EMB_DIM / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ADDR_W = IDX_WIDTH + $clog2(BEATS);
    localparam int WORD_W = LANES * DATA_WIDTH;
    localparam int DEPTH  = NUM_ENTRIES * BEATS;

    localparam logic [IDX_WIDTH:0]  IDX_LIMIT = (IDX_WIDTH + 1)'(NUM_ENTRIES);
    localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic                   err_q, err_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic                   in_ready_q, in_ready_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [WORD_W-1:0]      data_q, data_d;
    logic [WORD_W-1:0]      rd_data_q;
    logic [ADDR_W-1:0]      rd_addr;

    logic [WORD_W-1:0]      mem_q [DEPTH];

    initial begin
        mem_q = '{default: '0};
    end

    assign rd_addr = ADDR_W'(idx_q) * ADDR_W'(BEATS) + ADDR_W'(beat_q);

    // Out-of-range transactions never touch the array.
    always_ff @(posedge clk) begin
        if (state_q == FETCH && !err_q) rd_data_q <= mem_q[rd_addr];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        beat_d  = beat_q;
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    idx_d   = in_index;
                    err_d   = ({1'b0, in_index} >= IDX_LIMIT);
                    beat_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                data_d  = err_q ? '0 : rd_data_q;
                last_d  = (beat_q == LAST_BEAT);
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready_d = (state_d == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            err_q      <= 1'b0;
            beat_q     <= '0;
            in_ready_q <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            beat_q     <= beat_d;
            in_ready_q <= in_ready_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            data_q     <= data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_err   = err_q;
    assign out_index = idx_q;

endmodule

// File: tb/tb_embedding_stream_lookup.sv
// tb/tb_embedding_stream_lookup.sv - directed vector bench for embedding_stream_lookup
module tb_embedding_stream_lookup;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int          sel;
    logic        t_in_valid;
    logic        t_out_ready;
    logic [9:0]  t_in_index;

    logic a_in_ready, a_out_valid, a_out_last, a_out_err; logic [31:0] a_out_data; logic [9:0] a_out_index;
    logic b_in_ready, b_out_valid, b_out_last, b_out_err; logic [31:0] b_out_data; logic [9:0] b_out_index;
    logic c_in_ready, c_out_valid, c_out_last, c_out_err; logic [63:0] c_out_data; logic [9:0] c_out_index;
    logic d_in_ready, d_out_valid, d_out_last, d_out_err; logic [7:0]  d_out_data; logic [9:0] d_out_index;

    logic m_in_ready, m_out_valid, m_out_last, m_out_err;
    logic [63:0] m_out_data;
    logic [9:0]  m_out_index;

    embedding_stream_lookup u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid && sel == 0), .in_ready(a_in_ready),
        .in_index(t_in_index), .out_valid(a_out_valid), .out_ready(t_out_ready && sel == 0),
        .out_data(a_out_data), .out_last(a_out_last), .out_err(a_out_err), .out_index(a_out_index)
    );

    embedding_stream_lookup #(.NUM_ENTRIES(1000)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid && sel == 1), .in_ready(b_in_ready),
        .in_index(t_in_index), .out_valid(b_out_valid), .out_ready(t_out_ready && sel == 1),
        .out_data(b_out_data), .out_last(b_out_last), .out_err(b_out_err), .out_index(b_out_index)
    );

    embedding_stream_lookup #(.LANES(8)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid && sel == 2), .in_ready(c_in_ready),
        .in_index(t_in_index), .out_valid(c_out_valid), .out_ready(t_out_ready && sel == 2),
        .out_data(c_out_data), .out_last(c_out_last), .out_err(c_out_err), .out_index(c_out_index)
    );

    embedding_stream_lookup #(.LANES(1)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid && sel == 3), .in_ready(d_in_ready),
        .in_index(t_in_index), .out_valid(d_out_valid), .out_ready(t_out_ready && sel == 3),
        .out_data(d_out_data), .out_last(d_out_last), .out_err(d_out_err), .out_index(d_out_index)
    );

    always_comb begin
        m_in_ready = 1'b0; m_out_valid = 1'b0; m_out_last = 1'b0; m_out_err = 1'b0;
        m_out_data = '0;   m_out_index = '0;
        case (sel)
            0: begin m_in_ready = a_in_ready; m_out_valid = a_out_valid; m_out_last = a_out_last;
                     m_out_err = a_out_err; m_out_data = 64'(a_out_data); m_out_index = a_out_index; end
            1: begin m_in_ready = b_in_ready; m_out_valid = b_out_valid; m_out_last = b_out_last;
                     m_out_err = b_out_err; m_out_data = 64'(b_out_data); m_out_index = b_out_index; end
            2: begin m_in_ready = c_in_ready; m_out_valid = c_out_valid; m_out_last = c_out_last;
                     m_out_err = c_out_err; m_out_data = c_out_data; m_out_index = c_out_index; end
            default: begin m_in_ready = d_in_ready; m_out_valid = d_out_valid; m_out_last = d_out_last;
                     m_out_err = d_out_err; m_out_data = 64'(d_out_data); m_out_index = d_out_index; end
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Image content per instance: sel 0/1 {e,b,A5,3C}; sel 2 lane k = {e[3:0],k}; sel 3 {e[3:0],b}.
    function automatic logic [63:0] img(input int s, input int e, input int b);
        logic [7:0]  e8;
        logic [7:0]  b8;
        logic [63:0] w;
        e8 = 8'(e);
        b8 = 8'(b);
        w  = '0;
        case (s)
            0, 1: w = {32'h0, e8, b8, 8'hA5, 8'h3C};
            2: for (int k = 7; k >= 0; k--) w = {w[55:0], e8[3:0], 4'(k)};
            default: w = {56'h0, e8[3:0], b8[3:0]};
        endcase
        return w;
    endfunction

    function automatic int nbeats(input int s);
        return (s == 2) ? 1 : (s == 3) ? 8 : 2;
    endfunction

    typedef struct {
        int          sel;
        logic [9:0]  idx;
        logic        err;
        logic [63:0] d0;
        logic [63:0] dl;
    } vec_t;

    vec_t tbl [10];

    task automatic wait_ready();
        int n;
        n = 0;
        while (!m_in_ready && n < 20) begin @(negedge clk); n++; end
        chk("in_ready_wait", 64'(m_in_ready), 64'd1);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int nb;
        int n;
        logic [63:0] exp;
        sel = v.sel;
        nb = nbeats(v.sel);
        t_out_ready = 1'b1;
        @(negedge clk);
        wait_ready();
        t_in_valid = 1'b1;
        t_in_index = v.idx;
        @(negedge clk);
        t_in_valid = 1'b0;
        n = 1;
        while (!m_out_valid && n < 20) begin @(negedge clk); n++; end
        chk($sformatf("v%0d_latency", i), 64'(n), 64'd3);
        for (int b = 0; b < nb; b++) begin
            if (b > 0) begin
                n = 1;
                while (!m_out_valid && n < 20) begin @(negedge clk); n++; end
                chk($sformatf("v%0d_b%0d_spacing", i, b), 64'(n), 64'd3);
            end
            exp = (b == 0) ? v.d0 : (b == nb - 1) ? v.dl : img(v.sel, int'(v.idx), b);
            chk($sformatf("v%0d_b%0d_data", i, b), m_out_data, exp);
            chk($sformatf("v%0d_b%0d_last", i, b), 64'(m_out_last), 64'(b == nb - 1));
            chk($sformatf("v%0d_b%0d_err", i, b), 64'(m_out_err), 64'(v.err));
            chk($sformatf("v%0d_b%0d_index", i, b), 64'(m_out_index), 64'(v.idx));
            @(negedge clk);
        end
        chk($sformatf("v%0d_ready_after", i), 64'(m_in_ready), 64'd1);
        chk($sformatf("v%0d_valid_after", i), 64'(m_out_valid), 64'd0);
    endtask

    logic [63:0] got_data [4];
    logic [9:0]  got_idx  [4];

    initial begin
        int n, cyc, acc, nbeat, last1, acc2, stray;

        tbl[0] = '{0, 10'd5,    1'b0, 64'h0500A53C, 64'h0501A53C};
        tbl[1] = '{0, 10'd1023, 1'b0, 64'hFF00A53C, 64'hFF01A53C};
        tbl[2] = '{0, 10'd0,    1'b0, 64'h0000A53C, 64'h0001A53C};
        tbl[3] = '{1, 10'd1000, 1'b1, 64'h0,        64'h0};
        tbl[4] = '{1, 10'd999,  1'b0, 64'hE700A53C, 64'hE701A53C};
        tbl[5] = '{1, 10'd1023, 1'b1, 64'h0,        64'h0};
        tbl[6] = '{2, 10'd3,    1'b0, 64'h3736353433323130, 64'h3736353433323130};
        tbl[7] = '{2, 10'd1023, 1'b0, 64'hF7F6F5F4F3F2F1F0, 64'hF7F6F5F4F3F2F1F0};
        tbl[8] = '{3, 10'd9,    1'b0, 64'h90,       64'h97};
        tbl[9] = '{3, 10'd42,   1'b0, 64'hA0,       64'hA7};

        rst_n = 1'b0;
        sel = 0;
        t_in_valid = 1'b0;
        t_out_ready = 1'b0;
        t_in_index = '0;

        #1;
        for (int e = 0; e < 1024; e++) begin
            for (int b = 0; b < 2; b++) u_a.mem_q[11'(e * 2 + b)] = 32'(img(0, e, b));
            if (e < 1000) for (int b = 0; b < 2; b++) u_b.mem_q[11'(e * 2 + b)] = 32'(img(1, e, b));
            u_c.mem_q[10'(e)] = img(2, e, 0);
            for (int b = 0; b < 8; b++) u_d.mem_q[13'(e * 8 + b)] = 8'(img(3, e, b));
        end

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(m_in_ready), 64'd0);
        chk("rst_out_valid", 64'(m_out_valid), 64'd0);
        chk("rst_out_last", 64'(m_out_last), 64'd0);
        chk("rst_out_err", 64'(m_out_err), 64'd0);
        chk("rst_out_data", m_out_data, 64'd0);
        chk("rst_out_index", 64'(m_out_index), 64'd0);
        rst_n = 1'b1;
        chk("release_in_ready_low", 64'(m_in_ready), 64'd0);
        @(negedge clk);
        chk("release_in_ready_high", 64'(m_in_ready), 64'd1);

        for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

        // Back-to-back indices with in_valid held high throughout.
        sel = 0;
        t_out_ready = 1'b1;
        @(negedge clk);
        wait_ready();
        t_in_valid = 1'b1;
        t_in_index = 10'd1023;
        cyc = 0; acc = 0; nbeat = 0; last1 = -1; acc2 = -2;
        while ((acc < 2 || nbeat < 4) && cyc < 60) begin
            if (t_in_valid && m_in_ready) begin
                acc++;
                if (acc == 2) acc2 = cyc;
            end
            if (m_out_valid && nbeat < 4) begin
                got_data[nbeat] = m_out_data;
                got_idx[nbeat]  = m_out_index;
                if (nbeat == 1) last1 = cyc;
                nbeat++;
            end
            @(negedge clk);
            cyc++;
            if (acc == 1) t_in_index = 10'd0;
            if (acc == 2) t_in_valid = 1'b0;
        end
        t_in_valid = 1'b0;
        chk("b2b_accepts", 64'(acc), 64'd2);
        chk("b2b_beats", 64'(nbeat), 64'd4);
        chk("b2b_second_accept_cycle", 64'(acc2), 64'(last1 + 1));
        chk("b2b_d0", got_data[0], 64'hFF00A53C);
        chk("b2b_d1", got_data[1], 64'hFF01A53C);
        chk("b2b_d2", got_data[2], 64'h0000A53C);
        chk("b2b_d3", got_data[3], 64'h0001A53C);
        chk("b2b_i0", 64'(got_idx[0]), 64'd1023);
        chk("b2b_i1", 64'(got_idx[1]), 64'd1023);
        chk("b2b_i2", 64'(got_idx[2]), 64'd0);
        chk("b2b_i3", 64'(got_idx[3]), 64'd0);
        n = 0;
        while (!m_in_ready && n < 20) begin @(negedge clk); n++; end

        // Backpressure on beat 0.
        t_out_ready = 1'b0;
        wait_ready();
        t_in_valid = 1'b1;
        t_in_index = 10'd77;
        @(negedge clk);
        t_in_valid = 1'b0;
        n = 1;
        while (!m_out_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_latency", 64'(n), 64'd3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_valid", c), 64'(m_out_valid), 64'd1);
            chk($sformatf("bp_hold%0d_data", c), m_out_data, 64'h4D00A53C);
            chk($sformatf("bp_hold%0d_last", c), 64'(m_out_last), 64'd0);
        end
        t_out_ready = 1'b1;
        @(negedge clk);
        n = 1;
        while (!m_out_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_release_gap", 64'(n), 64'd3);
        chk("bp_b1_data", m_out_data, 64'h4D01A53C);
        chk("bp_b1_last", 64'(m_out_last), 64'd1);
        @(negedge clk);
        chk("bp_ready_after", 64'(m_in_ready), 64'd1);

        // Reset while beat 0 waits in SEND.
        t_out_ready = 1'b0;
        wait_ready();
        t_in_valid = 1'b1;
        t_in_index = 10'd5;
        @(negedge clk);
        t_in_valid = 1'b0;
        n = 1;
        while (!m_out_valid && n < 20) begin @(negedge clk); n++; end
        chk("mid_rst_valid_before", 64'(m_out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(m_out_valid), 64'd0);
        chk("mid_rst_ready", 64'(m_in_ready), 64'd0);
        chk("mid_rst_data", m_out_data, 64'd0);
        chk("mid_rst_last", 64'(m_out_last), 64'd0);
        chk("mid_rst_err", 64'(m_out_err), 64'd0);
        chk("mid_rst_index", 64'(m_out_index), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t_out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(m_in_ready), 64'd1);
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            if (m_out_valid) stray++;
            @(negedge clk);
        end
        chk("post_rst_no_stray", 64'(stray), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
